// File: rtl/dsp_pkg.sv
// Shared DSP definitions: default channel count, sample width and channel-id type.
package dsp_pkg;

    localparam int N_CH   = 4;
    localparam int DATA_W = 14;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef logic [CH_W-1:0] ch_id_t;

endpackage

// File: rtl/dsp_tag_fifo.sv
// In-order FIFO of channel tags for samples currently inside the rectifier.
module dsp_tag_fifo
    import dsp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(ch_id_t)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count != ($clog2(DEPTH)+1)'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dsp_rect_sched.sv
// Round-robin scheduler sharing one in-order rectifier among N_CH sample channels,
// returning each result tagged with the channel that issued it.
module dsp_rect_sched
    import dsp_pkg::*;
#(
    parameter int N_CH      = dsp_pkg::N_CH,
    parameter int DATA_W    = dsp_pkg::DATA_W,
    parameter int TAG_DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_CH-1:0][DATA_W-1:0] i_ch_data,
    input  logic [N_CH-1:0]             i_ch_valid,
    output logic [N_CH-1:0]             o_ch_ready,
    output logic [DATA_W-1:0]           o_rect_data,
    output logic                        o_rect_valid,
    input  logic [DATA_W-1:0]           i_rect_data,
    input  logic                        i_rect_valid,
    output logic [DATA_W-1:0]           o_data,
    output logic [$clog2(N_CH)-1:0]     o_ch_id,
    output logic                        o_valid,
    output logic                        o_err
);

    localparam int ID_W  = $clog2(N_CH);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  head_tag;
    logic             grant_found;
    logic             full;
    logic             transfer;
    logic             pop;
    logic             spurious;
    logic [CNT_W-1:0] outstanding;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned.
    always_comb begin
        grant_idx   = rr_ptr;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_CH);
            if (!grant_found && i_ch_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A pop in the same cycle does not free a slot: grants wait for the count to drop.
    assign full = (outstanding == CNT_W'(TAG_DEPTH));

    always_comb begin
        o_ch_ready = '0;
        if (grant_found && !full && !i_rst) begin
            o_ch_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = |o_ch_ready;
    assign pop      = i_rect_valid && (outstanding != '0);
    assign spurious = i_rect_valid && (outstanding == '0);

    dsp_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (transfer),
        .push_data (grant_idx),
        .pop       (pop),
        .head      (head_tag),
        .count     (outstanding)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_ptr       <= '0;
            o_rect_valid <= 1'b0;
            o_rect_data  <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            o_ch_id      <= '0;
            o_err        <= 1'b0;
        end else begin
            o_rect_valid <= transfer;
            if (transfer) begin
                o_rect_data <= i_ch_data[grant_idx];
                rr_ptr      <= (grant_idx == ID_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
            o_valid <= pop;
            if (pop) begin
                o_data  <= i_rect_data;
                o_ch_id <= head_tag;
            end
            if (spurious) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsp_rect_sched.sv
// Randomised bench for dsp_rect_sched with a behavioural rectifier pipe and scoreboard.
module tb_dsp_rect_sched;

    localparam int N_CH      = 4;
    localparam int DATA_W    = 14;
    localparam int TAG_DEPTH = 8;

    logic                        i_clk = 1'b0;
    logic                        i_rst;
    logic [N_CH-1:0][DATA_W-1:0] i_ch_data;
    logic [N_CH-1:0]             i_ch_valid;
    logic [N_CH-1:0]             o_ch_ready;
    logic [DATA_W-1:0]           o_rect_data;
    logic                        o_rect_valid;
    logic [DATA_W-1:0]           i_rect_data;
    logic                        i_rect_valid;
    logic [DATA_W-1:0]           o_data;
    logic [1:0]                  o_ch_id;
    logic                        o_valid;
    logic                        o_err;

    always #5 i_clk = ~i_clk;

    dsp_rect_sched #(
        .N_CH      (N_CH),
        .DATA_W    (DATA_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ch_data    (i_ch_data),
        .i_ch_valid   (i_ch_valid),
        .o_ch_ready   (o_ch_ready),
        .o_rect_data  (o_rect_data),
        .o_rect_valid (o_rect_valid),
        .i_rect_data  (i_rect_data),
        .i_rect_valid (i_rect_valid),
        .o_data       (o_data),
        .o_ch_id      (o_ch_id),
        .o_valid      (o_valid),
        .o_err        (o_err)
    );

    typedef struct { int due; logic [DATA_W-1:0] d; } rect_t;
    typedef struct { int ch; int val; } res_t;

    rect_t rq[$];
    res_t  got_q[$];
    res_t  exp_q[$];

    int n_tests;
    int n_fail;
    int cyc;
    int rect_lat;
    bit inj;
    int m_out;
    int m_rr;

    function automatic int abs_val(input logic [DATA_W-1:0] d);
        int v;
        v = int'($signed(d));
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [DATA_W-1:0] rect_fn(input logic [DATA_W-1:0] d);
        return d[DATA_W-1] ? (~d + 1'b1) : d;
    endfunction

    function automatic logic [N_CH-1:0][DATA_W-1:0] rand_data();
        logic [N_CH-1:0][DATA_W-1:0] r;
        for (int c = 0; c < N_CH; c++) r[c] = DATA_W'($urandom);
        return r;
    endfunction

    // One clock: advance the rectifier model, collect results, drive channels, predict the grant.
    task automatic cycle(input logic [N_CH-1:0] mask, input logic [N_CH-1:0][DATA_W-1:0] data,
                         output logic [N_CH-1:0] exp_ready);
        bit       pop;
        bit       push;
        int       pre;
        logic [1:0] idx;
        int       g;
        @(negedge i_clk);
        cyc++;
        if (o_valid) got_q.push_back('{int'(o_ch_id), int'(o_data)});
        if (o_rect_valid) rq.push_back('{cyc + rect_lat, rect_fn(o_rect_data)});
        pop = 1'b0;
        i_rect_valid = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            i_rect_valid = 1'b1;
            i_rect_data  = rq[0].d;
            void'(rq.pop_front());
            pop = 1'b1;
        end else if (inj) begin
            i_rect_valid = 1'b1;
            i_rect_data  = DATA_W'($urandom);
            pop = 1'b1;
            inj = 1'b0;
        end
        i_ch_valid = mask;
        i_ch_data  = data;
        exp_ready  = '0;
        push = 1'b0;
        pre  = m_out;
        if (!i_rst && m_out < TAG_DEPTH && mask != '0) begin
            g = -1;
            for (int k = 0; k < N_CH; k++) begin
                idx = 2'((m_rr + k) % N_CH);
                if (g < 0 && mask[idx]) g = int'(idx);
            end
            idx = 2'(g);
            exp_ready[idx] = 1'b1;
            exp_q.push_back('{g, abs_val(data[idx])});
            m_rr = (g + 1) % N_CH;
            push = 1'b1;
        end
        if (i_rst) begin
            m_out = 0;
            m_rr  = 0;
        end else begin
            m_out = pre + int'(push) - int'(pop && pre > 0);
        end
        #1;
    endtask

    task automatic drain();
        logic [N_CH-1:0] r;
        int guard = 0;
        while ((rq.size() > 0 || m_out > 0) && guard < 200) begin
            cycle('0, '0, r);
            guard++;
        end
        cycle('0, '0, r);
        cycle('0, '0, r);
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL drain_timeout: outstanding %0d pending %0d after %0d cycles", m_out, rq.size(), guard);
        end
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_ch_valid = '0;
        i_rect_valid = 1'b0;
        inj = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        rq.delete();
        got_q.delete();
        exp_q.delete();
        m_out = 0;
        m_rr  = 0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_ch_valid = '1;
        #2;
        n_tests += 9;
        if (o_rect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rect_valid: got %b want 0", o_rect_valid); end
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", o_err); end
        if (o_rect_data !== '0) begin n_fail++; $display("FAIL reset_rect_data: got %h want 0", o_rect_data); end
        if (o_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_data); end
        if (o_ch_id !== '0) begin n_fail++; $display("FAIL reset_ch_id: got %0d want 0", o_ch_id); end
        if (o_ch_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", o_ch_ready); end
        if (dut.rr_ptr !== '0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
        if (dut.outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", dut.outstanding); end
        i_ch_valid = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_single_channel();
        logic [N_CH-1:0][DATA_W-1:0] d;
        logic [N_CH-1:0] er;
        int guard = 0;
        apply_reset();
        rect_lat = 3;
        d = rand_data();
        d[2] = 14'h3FF0;
        cycle(4'b0100, d, er);
        n_tests++;
        if (o_ch_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", o_ch_ready); end
        cycle('0, '0, er);
        n_tests += 2;
        if (o_rect_valid !== 1'b1) begin n_fail++; $display("FAIL single_rect_valid: got %b want 1", o_rect_valid); end
        if (o_rect_data !== 14'h3FF0) begin n_fail++; $display("FAIL single_rect_data: got %h want 3ff0", o_rect_data); end
        cycle('0, '0, er);
        n_tests++;
        if (o_rect_valid !== 1'b0) begin n_fail++; $display("FAIL single_rect_pulse: got %b want 0", o_rect_valid); end
        while (got_q.size() == 0 && guard < 10) begin
            cycle('0, '0, er);
            guard++;
        end
        n_tests++;
        if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_timeout: got no result want 1 result");
        end else begin
            n_tests += 2;
            if (got_q[0].ch != 2) begin n_fail++; $display("FAIL single_ch_id: got %0d want 2", got_q[0].ch); end
            if (got_q[0].val != 16) begin n_fail++; $display("FAIL single_data: got %0d want 16", got_q[0].val); end
        end
    endtask

    task automatic test_round_robin();
        logic [N_CH-1:0] er;
        apply_reset();
        rect_lat = 3;
        for (int i = 0; i < 12; i++) begin
            cycle(4'hF, rand_data(), er);
            n_tests++;
            if (o_ch_ready !== (4'b0001 << (i % 4))) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, o_ch_ready, 4'b0001 << (i % 4));
            end
        end
        drain();
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rr_count: got %0d results want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[i] != exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rr_result[%0d]: got ch%0d/%0d want ch%0d/%0d", i, got_q[i].ch, got_q[i].val, exp_q[i].ch, exp_q[i].val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N_CH-1:0] er;
        int grants9 = 0;
        int resume  = -1;
        int max_out = 0;
        apply_reset();
        rect_lat = 12;
        for (int i = 0; i < 30; i++) begin
            cycle(4'hF, rand_data(), er);
            if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
            n_tests++;
            if (o_ch_ready !== er) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, o_ch_ready, er); end
            if (i < 9 && o_ch_ready != '0) grants9++;
            if (i >= 8 && resume < 0 && o_ch_ready != '0) resume = i;
        end
        n_tests += 3;
        if (grants9 != 8) begin n_fail++; $display("FAIL bp_first_grants: got %0d want 8", grants9); end
        if (resume != 14) begin n_fail++; $display("FAIL bp_resume_cycle: got %0d want 14", resume); end
        if (max_out != TAG_DEPTH) begin n_fail++; $display("FAIL bp_max_outstanding: got %0d want %0d", max_out, TAG_DEPTH); end
        drain();
        rect_lat = 3;
        for (int i = 0; i < 40; i++) begin
            cycle(4'hF, rand_data(), er);
            if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
            n_tests++;
            if (o_ch_ready !== er) begin n_fail++; $display("FAIL lat3_ready[%0d]: got %b want %b", i, o_ch_ready, er); end
        end
        drain();
        n_tests += 2;
        if (max_out > TAG_DEPTH) begin n_fail++; $display("FAIL lat3_outstanding: got %0d want <= %0d", max_out, TAG_DEPTH); end
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[i] != exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_result[%0d]: got ch%0d/%0d want ch%0d/%0d", i, got_q[i].ch, got_q[i].val, exp_q[i].ch, exp_q[i].val);
                end
            end
        end
    endtask

    task automatic test_spurious();
        logic [N_CH-1:0] er;
        apply_reset();
        rect_lat = 3;
        inj = 1'b1;
        cycle('0, '0, er);
        for (int i = 0; i < 5; i++) begin
            cycle('0, '0, er);
            n_tests += 2;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL spur_valid[%0d]: got %b want 0", i, o_valid); end
            if (o_err !== 1'b1) begin n_fail++; $display("FAIL spur_err[%0d]: got %b want 1", i, o_err); end
        end
        n_tests++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL spur_results: got %0d want 0", got_q.size()); end
        apply_reset();
        n_tests++;
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL spur_err_clear: got %b want 0", o_err); end
    endtask

    task automatic test_async_reset();
        logic [N_CH-1:0] er;
        int guard = 0;
        apply_reset();
        rect_lat = 20;
        for (int i = 0; i < 5; i++) cycle(4'b0001, rand_data(), er);
        @(posedge i_clk);
        #2;
        n_tests++;
        if (dut.outstanding !== 4'd5) begin n_fail++; $display("FAIL arst_pre_outstanding: got %0d want 5", dut.outstanding); end
        i_rst = 1'b1;
        #1;
        n_tests += 9;
        if (o_rect_valid !== 1'b0) begin n_fail++; $display("FAIL arst_rect_valid: got %b want 0", o_rect_valid); end
        if (o_rect_data !== '0) begin n_fail++; $display("FAIL arst_rect_data: got %h want 0", o_rect_data); end
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", o_valid); end
        if (o_data !== '0) begin n_fail++; $display("FAIL arst_data: got %h want 0", o_data); end
        if (o_ch_id !== '0) begin n_fail++; $display("FAIL arst_ch_id: got %0d want 0", o_ch_id); end
        if (o_err !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b want 0", o_err); end
        if (o_ch_ready !== '0) begin n_fail++; $display("FAIL arst_ready: got %b want 0000", o_ch_ready); end
        if (dut.outstanding !== '0) begin n_fail++; $display("FAIL arst_outstanding: got %0d want 0", dut.outstanding); end
        if (dut.rr_ptr !== '0) begin n_fail++; $display("FAIL arst_rr_ptr: got %0d want 0", dut.rr_ptr); end
        exp_q.delete();
        cycle('0, '0, er);
        cycle('0, '0, er);
        i_rst = 1'b0;
        while (rq.size() > 0 && guard < 40) begin
            cycle('0, '0, er);
            guard++;
            n_tests++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_stale_valid[%0d]: got %b want 0", guard, o_valid); end
        end
        cycle('0, '0, er);
        n_tests += 3;
        if (guard >= 40) begin n_fail++; $display("FAIL arst_timeout: pending %0d want 0", rq.size()); end
        if (o_err !== 1'b1) begin n_fail++; $display("FAIL arst_err_after: got %b want 1", o_err); end
        if (got_q.size() != 0) begin n_fail++; $display("FAIL arst_results: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_random();
        logic [N_CH-1:0] er;
        int guard = 0;
        apply_reset();
        rect_lat = 9;
        while (exp_q.size() < 420 && guard < 5000) begin
            cycle(4'($urandom_range(0, 15)), rand_data(), er);
            guard++;
            n_tests++;
            if (o_ch_ready !== er) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", guard, o_ch_ready, er); end
        end
        drain();
        n_tests++;
        if (got_q.size() != 420 || exp_q.size() != 420) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results want 420 (model %0d)", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 420; i++) begin
                n_tests++;
                if (got_q[i] != exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_result[%0d]: got ch%0d/%0d want ch%0d/%0d", i, got_q[i].ch, got_q[i].val, exp_q[i].ch, exp_q[i].val);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        inj     = 1'b0;
        m_out   = 0;
        m_rr    = 0;
        rect_lat = 3;
        i_rst = 1'b0;
        i_ch_valid = '0;
        i_ch_data  = '0;
        i_rect_valid = 1'b0;
        i_rect_data  = '0;
        #1;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_back_to_back();
        test_spurious();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule
